// File: rtl/pipeline_stage_buf_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipeline : shared core pipeline types and stage-buffer defaults          |
// | Rev 1.0  : initial release                                               |
// +--------------------------------------------------------------------------+
package pipeline;

  localparam int STAGE_BUF_DEPTH = 2;

  typedef logic [15:0] stall_cnt_t;

  localparam int STALL_CNT_W = $bits(stall_cnt_t);

endpackage
`default_nettype wire

// File: rtl/pipeline_stage_buf_sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sat_counter : up-counter that sticks at all-ones, async active-low reset |
// | Rev 1.0     : initial release                                            |
// +--------------------------------------------------------------------------+
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule
`default_nettype wire

// File: rtl/pipeline_stage_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipeline_stage_buf : elastic valid/ready register between pipe stages    |
// | Rev 1.0            : initial release                                     |
// +--------------------------------------------------------------------------+
module pipeline_stage_buf
  import pipeline::*;
#(
  parameter int PAYLOAD_W = 32,
  parameter int DEPTH     = STAGE_BUF_DEPTH,
  parameter int CNT_W     = STALL_CNT_W
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PAYLOAD_W-1:0]         in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PAYLOAD_W-1:0]         out_data,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [CNT_W-1:0]             stall_cycles
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  generate
    if ((DEPTH < 1) || (DEPTH > 4) || (PAYLOAD_W < 1)) begin : g_bad_param
      $error("pipeline_stage_buf: DEPTH must be 1..4 and PAYLOAD_W >= 1");
    end
  endgenerate

  logic [PAYLOAD_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]     count_q, count_d;
  logic                 push, pop, stall;

  // Handshake outputs come from registered count only, so out_ready never reaches in_ready.
  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign occupancy = count_q;

  assign push  = in_valid & in_ready & ~flush;
  assign pop   = out_valid & out_ready;
  assign stall = out_valid & ~out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + OCC_W'(1);
        2'b01:   count_d = count_q - OCC_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is deliberately unreset; out_data is masked by out_valid instead.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (stall),
    .q       (stall_cycles)
  );

  a_no_push_full : assert property (@(posedge clk) disable iff (!reset_n)
    push |-> (count_q != FULL_CNT));

  a_no_pop_empty : assert property (@(posedge clk) disable iff (!reset_n)
    pop |-> (count_q != '0));

  a_head_stable : assert property (@(posedge clk) disable iff (!reset_n)
    (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stage_buf.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipeline_stage_buf : three buffer configs against a queue model       |
// | Rev 1.0               : initial release                                  |
// +--------------------------------------------------------------------------+
module tb_pipeline_stage_buf;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        iv  [3];
  logic        ord [3];
  logic        fl  [3];
  logic [31:0] din [3];

  logic        ir0, ir1, ir2, ov0, ov1, ov2;
  logic [31:0] od0, od1, od2;
  logic [1:0]  occ0, occ1;
  logic [0:0]  occ2;
  logic [15:0] st0, st1;
  logic [3:0]  st2;

  always #5 clk = ~clk;

  pipeline_stage_buf #(.PAYLOAD_W(32), .DEPTH(2), .CNT_W(16)) u_d2 (
    .clk(clk), .reset_n(reset_n), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir0),
    .in_data(din[0]), .out_valid(ov0), .out_ready(ord[0]), .out_data(od0),
    .occupancy(occ0), .stall_cycles(st0));

  pipeline_stage_buf #(.PAYLOAD_W(32), .DEPTH(3), .CNT_W(16)) u_d3 (
    .clk(clk), .reset_n(reset_n), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir1),
    .in_data(din[1]), .out_valid(ov1), .out_ready(ord[1]), .out_data(od1),
    .occupancy(occ1), .stall_cycles(st1));

  pipeline_stage_buf #(.PAYLOAD_W(32), .DEPTH(1), .CNT_W(4)) u_d1 (
    .clk(clk), .reset_n(reset_n), .flush(fl[2]), .in_valid(iv[2]), .in_ready(ir2),
    .in_data(din[2]), .out_valid(ov2), .out_ready(ord[2]), .out_data(od2),
    .occupancy(occ2), .stall_cycles(st2));

  logic [31:0] a_ir [3], a_ov [3], a_od [3], a_occ [3], a_st [3];
  assign a_ir[0]  = 32'(ir0);  assign a_ir[1]  = 32'(ir1);  assign a_ir[2]  = 32'(ir2);
  assign a_ov[0]  = 32'(ov0);  assign a_ov[1]  = 32'(ov1);  assign a_ov[2]  = 32'(ov2);
  assign a_od[0]  = od0;       assign a_od[1]  = od1;       assign a_od[2]  = od2;
  assign a_occ[0] = 32'(occ0); assign a_occ[1] = 32'(occ1); assign a_occ[2] = 32'(occ2);
  assign a_st[0]  = 32'(st0);  assign a_st[1]  = 32'(st1);  assign a_st[2]  = 32'(st2);

  // Reference: a bounded FIFO queue plus a saturating stall tally per instance.
  int          dep  [3] = '{2, 3, 1};
  int          smax [3] = '{65535, 65535, 15};
  logic [31:0] mq   [3][$];
  int          mst  [3];

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string ph);
    for (int i = 0; i < 3; i++) begin
      int sz;
      sz = mq[i].size();
      check($sformatf("%s.u%0d.in_ready", ph, i), a_ir[i], 32'(sz < dep[i]));
      check($sformatf("%s.u%0d.out_valid", ph, i), a_ov[i], 32'(sz > 0));
      check($sformatf("%s.u%0d.out_data", ph, i), a_od[i], (sz > 0) ? mq[i][0] : 32'h0);
      check($sformatf("%s.u%0d.occupancy", ph, i), a_occ[i], 32'(sz));
      check($sformatf("%s.u%0d.stall", ph, i), a_st[i], 32'(mst[i]));
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      int sz;
      bit ps, pp;
      sz = mq[i].size();
      ps = iv[i] && (sz < dep[i]) && !fl[i];
      pp = (sz > 0) && ord[i];
      if ((sz > 0) && !ord[i] && (mst[i] < smax[i])) mst[i]++;
      if (fl[i]) begin
        mq[i].delete();
      end else begin
        if (pp) void'(mq[i].pop_front());
        if (ps) mq[i].push_back(din[i]);
      end
    end
  endtask

  task automatic step(input string ph);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(ph);
  endtask

  task automatic set_all(input bit v, input bit r, input bit f, input logic [31:0] d);
    for (int i = 0; i < 3; i++) begin
      iv[i] = v; ord[i] = r; fl[i] = f; din[i] = d;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mq[i].delete();
      mst[i] = 0;
    end
  endtask

  // Reset is asserted between edges so the check proves it acts without a clock.
  task automatic async_reset(input string ph);
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_all(ph);
    @(negedge clk);
    check_all({ph, "_held"});
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    set_all(1'b0, 1'b0, 1'b0, 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    check_all("por");
    reset_n = 1'b1;

    for (int k = 0; k < 16; k++) begin
      set_all(1'b1, 1'b1, 1'b0, 32'(k + 1));
      step("stream");
    end
    set_all(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (4) step("stream_drain");

    set_all(1'b1, 1'b0, 1'b0, 32'hA); step("bp");
    din = '{32'hB, 32'hB, 32'hB};     step("bp");
    din = '{32'hC, 32'hC, 32'hC};     step("bp");
    step("bp");
    check("bp.occ_full", a_occ[0], 32'd2);
    check("bp.in_ready_low", a_ir[0], 32'd0);
    set_all(1'b1, 1'b1, 1'b0, 32'hC);
    repeat (2) step("bp_drain");
    set_all(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (4) step("bp_drain");

    set_all(1'b1, 1'b0, 1'b0, 32'h77);
    repeat (2) step("pre_rst");
    async_reset("mid_rst");

    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 3; i++) begin
        iv[i]  = ($urandom_range(0, 3) != 0);
        ord[i] = ($urandom_range(0, 2) != 0);
        fl[i]  = ($urandom_range(0, 15) == 0);
        din[i] = $urandom;
      end
      step("rand");
    end

    set_all(1'b1, 1'b0, 1'b0, 32'h21);
    repeat (3) step("pre_flush");
    set_all(1'b1, 1'b0, 1'b1, 32'h55);
    step("flush");
    check("flush.out_valid", a_ov[0], 32'd0);
    check("flush.occupancy", a_occ[0], 32'd0);
    set_all(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (3) step("post_flush");

    async_reset("rst2");
    set_all(1'b1, 1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 10; k++) begin
      din = '{32'(k + 32'h100), 32'(k + 32'h100), 32'(k + 32'h100)};
      step("d1_stream");
    end
    set_all(1'b1, 1'b0, 1'b0, 32'h3C);
    repeat (20) step("sat");
    check("sat.stall_d1", a_st[2], 32'd15);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
